data_access_ctrl: RTL
=====================

DATA_ACCESS_CTRL -- requirements
Module: data_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: cycles spent in WAIT without ack before a bus error.
REQ-002 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port req_valid, input, 1: a load or store request is presented this cycle.
REQ-005 Port req_op, input, 3: 0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
REQ-006 Port req_addr, input, 32: byte address.
REQ-007 Port req_wdata, input, 32: store data, right-aligned.
REQ-008 Port flush, input, 1: cancel the in-flight request.
REQ-009 Port data_sram_en, output, 1: memory request strobe.
REQ-010 Port data_sram_wen, output, 4: byte write enables; 0 for loads.
REQ-011 Port data_sram_addr, output, 32: word-aligned address (low 2 bits are 0).
REQ-012 Port data_sram_wdata, output, 32: store data replicated to the selected lanes.
REQ-013 Port data_sram_ack, input, 1: memory has completed the request; read data is valid in the same cycle.
REQ-014 Port data_sram_rdata, input, 32: read data.
REQ-015 Port stallreq, output, 1: pipeline stall request.
REQ-016 Port load_valid, output, 1: one-cycle pulse; load_data is valid.
REQ-017 Port load_data, output, 32: extended load result.
REQ-018 Port addr_err, output, 1: one-cycle misalignment pulse.
REQ-019 Port bus_err, output, 1: one-cycle timeout pulse.

Function
REQ-020 The FSM SHALL have three states: IDLE, WAIT and DRAIN.
REQ-021 IDLE + req_valid + aligned + !flush SHALL latch op, lane offset and data, assert data_sram_en, and enter WAIT on the next edge.
REQ-022 In WAIT, data_sram_en, data_sram_addr, data_sram_wen and data_sram_wdata SHALL be held stable until the ack cycle.
REQ-023 Byte enables SHALL be: SB -> 4'b0001 shifted left by addr[1:0]; SH -> 4'b0011 shifted left by addr[1]*2; SW -> 4'b1111.
REQ-024 Loads SHALL select the addressed byte or halfword from data_sram_rdata; LB/LH sign-extend to 32 bits and LBU/LHU zero-extend.
REQ-025 WAIT + ack SHALL pulse load_valid (loads only) in the ack cycle, combinationally from data_sram_rdata, and return to IDLE.
REQ-026 stallreq SHALL be 1 in the accept cycle and throughout WAIT and DRAIN, and 0 in the ack cycle.
REQ-027 Alignment SHALL be: halfword needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
REQ-028 WAIT + flush + !ack SHALL enter DRAIN; DRAIN SHALL keep the request stable, discard ack data (no load_valid), and go to IDLE on ack.
REQ-029 WAIT + flush + ack in the same cycle SHALL complete normally (ack wins) and return to IDLE.
REQ-030 IDLE + flush SHALL ignore req_valid.
REQ-031 An 8-bit wait counter SHALL clear on entry to WAIT and increment each WAIT/DRAIN cycle; reaching TIMEOUT_CYC SHALL pulse bus_err, drop data_sram_en and go to IDLE.
REQ-032 New requests SHALL only be accepted in IDLE; req_valid in other states SHALL be ignored, since stallreq holds the upstream stage.

Reset
REQ-033 rst SHALL force IDLE, clear the counter and latches, and drive every output to 0 on the next edge, including mid-WAIT/DRAIN.

Configuration
REQ-034 With UNALIGNED_EXC_EN defined, a misaligned request in IDLE SHALL pulse addr_err for one cycle, issue no memory access, assert no stallreq, and stay in IDLE.
REQ-035 Without UNALIGNED_EXC_EN, misaligned addresses SHALL be force-aligned (addr[0] cleared for halfword, addr[1:0] cleared for word), addr_err SHALL be tied to 0, and the access SHALL proceed.

Structure
REQ-036 The op encodings, state encodings and the TIMEOUT_CYC default SHALL live in the shared defines header next to the stall/bus-width defines.
REQ-037 Lane select plus extension SHALL be one combinational sub-module, load_align.

Verification
REQ-038 LW at 0x100 with ack at WAIT cycle 3 and rdata 0xDEADBEEF -> load_valid and load_data=0xDEADBEEF in the ack cycle, stallreq 1 for 3 cycles.
REQ-039 LB at 0x103 with rdata 0x80112233 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SH at 0x102 with wdata 0x1234 -> wen=4'b1100, wdata=0x12341234, addr=0x100.
REQ-041 LW in WAIT, flush at cycle 1, ack at cycle 4 -> no load_valid, IDLE after ack, stallreq low afterwards.
REQ-042 LH at 0x101 -> with UNALIGNED_EXC_EN: addr_err pulse, en=0; without it: access at 0x100, returns halfword 0.
REQ-043 No ack for 255 WAIT cycles -> bus_err pulse, then IDLE; separately, rst asserted mid-WAIT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/data_access_ctrl_pkg.sv
// Shared definitions for the data access controller: bus widths, stall width,
// memory op encodings, FSM state encodings and the default bus timeout.
package data_access_ctrl_pkg;

    localparam int BUS_W           = 32;   // data and address bus width
    localparam int BE_W            = 4;    // byte lanes per bus word
    localparam int STALL_W         = 1;    // pipeline stall request width
    localparam int CNT_W           = 8;    // wait counter width
    localparam int TIMEOUT_DEFAULT = 255;  // WAIT cycles without ack before bus error

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Access width implied by an op.
    function automatic size_e op_size(input op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    // True for the five load ops.
    function automatic logic op_is_load(input op_e op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

endpackage

// File: rtl/data_access_ctrl_load_align.sv
// Load lane select and sign/zero extension, purely combinational.
module load_align
    import data_access_ctrl_pkg::*;
(
    input  op_e              op,
    input  logic [1:0]       offset,
    input  logic [BUS_W-1:0] rdata,
    output logic [BUS_W-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/halfword, then extend according to the op.
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {24'h0, byte_sel};
            OP_LH:   data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/data_access_ctrl.sv
// Load/store controller between a pipeline stage and a data SRAM port.
// Accepts one request in IDLE, holds the memory request stable until ack,
// supports flush (DRAIN discards the late ack) and a wait-cycle timeout.
// Optional macro UNALIGNED_EXC_EN: misaligned requests raise addr_err and are
// dropped; without it they are force-aligned and proceed.
module data_access_ctrl
    import data_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [2:0]         req_op,
    input  logic [BUS_W-1:0]   req_addr,
    input  logic [BUS_W-1:0]   req_wdata,
    input  logic               flush,
    output logic               data_sram_en,
    output logic [BE_W-1:0]    data_sram_wen,
    output logic [BUS_W-1:0]   data_sram_addr,
    output logic [BUS_W-1:0]   data_sram_wdata,
    input  logic               data_sram_ack,
    input  logic [BUS_W-1:0]   data_sram_rdata,
    output logic [STALL_W-1:0] stallreq,
    output logic               load_valid,
    output logic [BUS_W-1:0]   load_data,
    output logic               addr_err,
    output logic               bus_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);

    state_e            state, state_n;
    op_e               op_in, op_q;
    size_e             size_in;
    logic [1:0]        off_in, off_q;
    logic [BE_W-1:0]   wen_in, wen_q;
    logic [BUS_W-1:0]  wdata_in, wdata_q, addr_in, addr_q, aligned_data;
    logic [CNT_W-1:0]  cnt;
    logic              req_ok, accept, timeout;

    assign op_in   = op_e'(req_op);
    assign size_in = op_size(op_in);
    assign addr_in = {req_addr[BUS_W-1:2], 2'b00};
    assign req_ok  = (state == ST_IDLE) && req_valid && !flush && !rst;

`ifdef UNALIGNED_EXC_EN
    logic misaligned;
    assign misaligned = ((size_in == SZ_HALF) && req_addr[0]) ||
                        ((size_in == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign accept   = req_ok && !misaligned;
    assign addr_err = req_ok && misaligned;
`else
    assign accept   = req_ok;
    assign addr_err = 1'b0;
`endif

    // Effective lane offset (force-aligned), byte enables and lane-replicated store data.
    always_comb begin
        off_in   = 2'b00;
        wen_in   = '0;
        wdata_in = '0;
        case (size_in)
            SZ_BYTE: begin
                off_in   = req_addr[1:0];
                wdata_in = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                off_in   = {req_addr[1], 1'b0};
                wdata_in = {2{req_wdata[15:0]}};
            end
            default: begin
                off_in   = 2'b00;
                wdata_in = req_wdata;
            end
        endcase
        if (!op_is_load(op_in)) begin
            case (size_in)
                SZ_BYTE: wen_in = 4'b0001 << off_in;
                SZ_HALF: wen_in = 4'b0011 << off_in;
                default: wen_in = 4'b1111;
            endcase
        end else begin
            wdata_in = '0;
        end
    end

    assign timeout = (state != ST_IDLE) && (cnt == TIMEOUT_LIM);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Request latches and wait counter (cleared on every accept).
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= OP_LB;
            off_q   <= '0;
            wen_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt     <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            off_q   <= off_in;
            wen_q   <= wen_in;
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            cnt     <= '0;
        end else if ((state != ST_IDLE) && !data_sram_ack && !timeout) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next state and memory/pipeline outputs.
    always_comb begin
        state_n         = state;
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        stallreq        = '0;
        load_valid      = 1'b0;
        bus_err         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    data_sram_en    = 1'b1;
                    data_sram_wen   = wen_in;
                    data_sram_addr  = addr_in;
                    data_sram_wdata = wdata_in;
                    stallreq        = 1'b1;
                    state_n         = ST_WAIT;
                end
            end
            ST_WAIT, ST_DRAIN: begin
                if (timeout) begin
                    bus_err = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    data_sram_en    = 1'b1;
                    data_sram_wen   = wen_q;
                    data_sram_addr  = addr_q;
                    data_sram_wdata = wdata_q;
                    if (data_sram_ack) begin
                        // Ack wins over a same-cycle flush; DRAIN drops the data.
                        load_valid = (state == ST_WAIT) && op_is_load(op_q);
                        state_n    = ST_IDLE;
                    end else begin
                        stallreq = 1'b1;
                        if ((state == ST_WAIT) && flush) state_n = ST_DRAIN;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    load_align u_load_align (
        .op     (op_q),
        .offset (off_q),
        .rdata  (data_sram_rdata),
        .data   (aligned_data)
    );

    assign load_data = load_valid ? aligned_data : '0;

endmodule
